// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchronizer plus stability-count filter for board switches.
// Drives the debounced level and registered one-cycle rise/fall pulses.
module switch_debouncer #(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 1000,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= RESET_VAL;
            s2     <= RESET_VAL;
            sw_out <= RESET_VAL;
            rise   <= '0;
            fall   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= sw_raw;
            s2   <= s1;
            rise <= '0;
            fall <= '0;
            // A bit only moves after STABLE_CYCLES consecutive edges of disagreement;
            // any agreement in between restarts its count from zero.
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s2[i] == sw_out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERM) begin
                    sw_out[i] <= s2[i];
                    rise[i]   <= s2[i];
                    fall[i]   <= ~s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronizes and debounces the raw 4-bit DIP-switch inputs before they reach the `switch` port of the 4-bit CPU. Each bit is synchronized by its own two-flop chain and filtered by its own stability counter. The debounced level is driven to the CPU. One-cycle rise and fall pulses are also provided for any consumer that needs edge events.

## Interface
- `WIDTH`, default 4: number of switch bits.
- `STABLE_CYCLES`, default 1000: consecutive cycles a synchronized bit must differ from its output before the output updates. Legal range is ≥1.
- `RESET_VAL`, default `'0`: value loaded into the sync flops and `sw_out` on reset.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sw_raw`  in  WIDTH  asynchronous switch levels from the board pins.
- `sw_out`  out  WIDTH  debounced level; connects to `cpu.switch`.
- `rise`  out  WIDTH  one-cycle pulse per bit when `sw_out[i]` goes 0→1.
- `fall`  out  WIDTH  one-cycle pulse per bit when `sw_out[i]` goes 1→0.

## Operation
- Synchronizer, per bit: `s1 <= sw_raw`, then `s2 <= s1`. Only `s2` feeds the filter. No combinational path exists from `sw_raw` to any output.
- Counter, per bit: `cnt[i]`, width `$clog2(STABLE_CYCLES+1)`, minimum 1 bit. All bits are fully independent.
- Filter rule, evaluated at each edge for each bit i:
  - If `s2[i] == sw_out[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == STABLE_CYCLES-1`: `sw_out[i] <= s2[i]` and `cnt[i] <= 0`. At the same edge, `rise[i] <= s2[i]` and `fall[i] <= ~s2[i]`.
  - Else: `cnt[i] <= cnt[i]+1`.
- `rise` and `fall` are registered. Each bit is 0 in every cycle except the one following an update. `rise[i]` and `fall[i]` are never both 1.
- Glitch handling: if `s2[i]` returns to `sw_out[i]` before the count completes, the counter clears. No output change and no pulse occur.
- Counter wrap is impossible: the counter saturates at `STABLE_CYCLES-1`, and the update clears it.
- `STABLE_CYCLES == 1`: an output updates on the first edge at which `s2` differs from it.

## Timing
- Reset values while `rst` is high at an edge:
  - `s1`, `s2`, `sw_out` = `RESET_VAL`.
  - `cnt` = 0.
  - `rise`, `fall` = 0.
- Reset has priority over all other updates.
- Reset mid-count discards the partial count. After release, a bit that differs from `RESET_VAL` needs the full latency again.
- Latency: `sw_raw[i]` changes before edge N and then stays stable.
  - `s1` updates at edge N.
  - `s2` updates at edge N+1.
  - The counter runs on edges N+2 through N+1+STABLE_CYCLES.
  - `sw_out[i]` and the pulse update at edge N+1+STABLE_CYCLES, which is `STABLE_CYCLES+2` edges in total.
  - The pulse clears at the following edge.
- Re-toggle: a new opposite-level change can begin counting on the edge right after an update. There is no dead time.
- Simultaneous events: bits changing in the same cycle with identical stable histories update on the same edge. Their pulses are asserted together.
- A change in `sw_raw` while `rst` is high is tracked by `s1`/`s2` only after release, because the sync flops are also held at `RESET_VAL`.

## Test plan
All scenarios use `WIDTH=4`, `STABLE_CYCLES=4`, `RESET_VAL=4'b0001`.
- Reset: hold `rst=1` for 3 cycles with `sw_raw=4'b1111`. Required: `sw_out=4'b0001`, `rise=fall=0` throughout reset.
- Clean change: release `rst` with `sw_raw=4'b0101`, stable. Required:
  - `sw_out` becomes `4'b0101` exactly 6 edges after the first post-reset edge.
  - `rise=4'b0100` for exactly one cycle.
  - `fall=0`.
- Glitch rejection: toggle `sw_raw[0]` low for 3 cycles, then restore it. Required: `sw_out` unchanged, no pulses, `cnt[0]` returns to 0.
- Bounce then settle: `sw_raw[1]` alternates 0/1 every cycle for 10 cycles, then holds 1. Required: `sw_out[1]` goes to 1 exactly 6 edges after the last transition, with a single `rise[1]` pulse.
- Mixed simultaneous: from `4'b0101`, set `sw_raw=4'b1010` in one cycle. Required:
  - All 4 bits update on the same edge.
  - `rise=4'b1010` and `fall=4'b0101` for one cycle.
- Reset mid-count: start a change on bit 3 and assert `rst` after 3 filter edges. Required:
  - `sw_out` returns to `4'b0001`.
  - After release with the input held, bit 3 updates only after the full 6-edge latency.
